// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared fetch-stage types, constants and byte-swap helper.
package mips_cpu_pkg;
    typedef enum logic [2:0] {IDLE, REQ, HOLD, HALTED, FAULT} fetch_state_t;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_PC = 32'h0;
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/mips_cpu_fetch.sv
// mips_cpu_fetch: one Avalon-MM read per instruction, valid/ready to decode, halt and fault detection.
module mips_cpu_fetch
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter bit SWAP_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_active,
    output logic [31:0] address,
    output logic        read,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        fault
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    fetch_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] address_q, instr_q, instr_pc_q;
    logic read_q, instr_valid_q, halted_q, fault_q;
    logic cnt_hit;
    // Timeout fires on the edge where the counter would reach TIMEOUT.
    assign cnt_hit = (TIMEOUT != 0) && (int'(cnt_q) + 1 >= TIMEOUT);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            address_q     <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            read_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pc_active || pc_in == HALT_PC) begin
                        halted_q <= 1'b1;
                        state_q  <= HALTED;
                    end else if (pc_in[1:0] != 2'b00) begin
                        fault_q <= 1'b1;
                        state_q <= FAULT;
                    end else begin
                        address_q  <= pc_in;
                        instr_pc_q <= pc_in;
                        read_q     <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (!waitrequest) begin
                        instr_q       <= SWAP_BYTES ? bswap32(readdata) : readdata;
                        read_q        <= 1'b0;
                        instr_valid_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= HOLD;
                    end else if (cnt_hit) begin
                        read_q  <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= FAULT;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
    assign address     = address_q;
    assign read        = read_q;
    assign byteenable  = {4{read_q}};
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
endmodule
